// File: rtl/encoder_8_3_pending.sv
// encoder_8_3_pending: latching 8-to-3 priority encoder for active-low event lines with valid/ready output
// Ports: clk, rst (async, active-high); req_n[7:0] async active-low requests;
//        mask[7:0] 1 = not eligible; code[2:0]/valid/ready handshake;
//        gs_n group select (0 when an unmasked pending bit exists); pending[7:0] raw event register.
module encoder_8_3_pending #(
  parameter int SYNC_STAGES = 2,
  parameter bit LOW_FIRST   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_n,
  input  logic [7:0] mask,
  output logic [2:0] code,
  output logic       valid,
  input  logic       ready,
  output logic       gs_n,
  output logic [7:0] pending
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] sync, prev, edges, elig, clr;
  logic [2:0] pick, code_n;
  assign sync  = sync_q[SYNC_STAGES-1];
  assign edges = prev & ~sync;
  assign elig  = pending & ~mask;
  assign gs_n  = ~|elig;
  assign clr   = (valid && ready) ? 8'(1) << code : 8'h00;
  always_comb begin
    pick = 3'd0;
    for (int i = 0; i < 8; i++)
      if (elig[LOW_FIRST ? 7 - i : i]) pick = LOW_FIRST ? 3'(7 - i) : 3'(i);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q  <= '1;
      prev    <= '1;
      pending <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], req_n};
      prev    <= sync;
      pending <= (pending & ~clr) | edges;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      code  <= 3'd0;
    end else begin
      state <= state_n;
      code  <= code_n;
    end
  always_comb begin
    state_n = (state == IDLE) ? (|elig ? PRESENT : IDLE) : (ready ? IDLE : PRESENT);
    code_n  = (state == IDLE && |elig) ? pick : code;
  end
  always_comb valid = (state == PRESENT);
endmodule

// File: tb/tb_encoder_8_3_pending.sv
// tb_encoder_8_3_pending: randomized and directed checks of two encoder configurations against a history-based model
module tb_encoder_8_3_pending;
  logic clk = 1'b0, rst = 1'b1, ready = 1'b0;
  logic [7:0] req_n = 8'hFF, mask = 8'h00;
  logic [2:0] code [2];
  logic [7:0] pending [2];
  logic valid [2], gs_n [2];
  int total = 0, bad = 0;
  logic [7:0] hist [2][5];
  logic [7:0] m_pend [2];
  logic [2:0] m_code [2];
  logic m_valid [2];
  always #5 clk = ~clk;
  encoder_8_3_pending #(.SYNC_STAGES(2), .LOW_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_n(req_n), .mask(mask), .code(code[0]), .valid(valid[0]),
    .ready(ready), .gs_n(gs_n[0]), .pending(pending[0]));
  encoder_8_3_pending #(.SYNC_STAGES(3), .LOW_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req_n(req_n), .mask(mask), .code(code[1]), .valid(valid[1]),
    .ready(ready), .gs_n(gs_n[1]), .pending(pending[1]));
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [2:0] prio(input logic [7:0] x, input bit low_first);
    int v = int'(x);
    return low_first ? 3'($clog2(v & -v)) : 3'($clog2(v + 1) - 1);
  endfunction
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 8'h00; m_code[d] = 3'd0; m_valid[d] = 1'b0;
      for (int k = 0; k < 5; k++) hist[d][k] = 8'hFF;
    end
  endtask
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int s = d ? 3 : 2;
      logic [7:0] ev, old, cl;
      ev  = hist[d][s] & ~hist[d][s-1];
      old = m_pend[d];
      cl  = (m_valid[d] && ready) ? 8'(1) << m_code[d] : 8'h00;
      m_pend[d] = (old & ~cl) | ev;
      if (m_valid[d]) begin
        if (ready) m_valid[d] = 1'b0;
      end else if ((old & ~mask) != 8'h00) begin
        m_valid[d] = 1'b1;
        m_code[d]  = prio(old & ~mask, d == 1);
      end
      for (int k = 4; k > 0; k--) hist[d][k] = hist[d][k-1];
      hist[d][0] = req_n;
    end
  endtask
  task automatic step(input logic [7:0] r, input logic [7:0] m, input logic rd);
    req_n = r; mask = m; ready = rd;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk(d ? "valid1" : "valid0", 8'(valid[d]), 8'(m_valid[d]));
      chk(d ? "code1" : "code0", 8'(code[d]), 8'(m_code[d]));
      chk(d ? "gs_n1" : "gs_n0", 8'(gs_n[d]), 8'(~|(m_pend[d] & ~mask)));
      chk(d ? "pending1" : "pending0", pending[d], m_pend[d]);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask
  initial begin
    logic [7:0] r, m;
    int n;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 8'(valid[0]), 8'h00);
    chk("rst_gs_n", 8'(gs_n[0]), 8'h01);
    chk("rst_pending", pending[0], 8'h00);
    repeat (6) step(8'hFF, 8'h00, 1'b1);
    chk("idle_pending", pending[0], 8'h00);
    step(8'hDF, 8'h00, 1'b1);
    step(8'hDF, 8'h00, 1'b1);
    step(8'hDF, 8'h00, 1'b1);
    chk("lat_pending", pending[0], 8'h20);
    chk("lat_novalid", 8'(valid[0]), 8'h00);
    step(8'hDF, 8'h00, 1'b1);
    chk("lat_valid", 8'(valid[0]), 8'h01);
    chk("lat_code", 8'(code[0]), 8'h05);
    step(8'hDF, 8'h00, 1'b1);
    chk("lat_clear", pending[0], 8'h00);
    repeat (8) step(8'hDF, 8'h00, 1'b1);
    repeat (4) step(8'hFF, 8'h00, 1'b1);
    repeat (14) step(8'b0110_1011, 8'h00, 1'b1);
    repeat (4) step(8'hFF, 8'h00, 1'b1);
    repeat (6) step(8'hF7, 8'h00, 1'b0);
    repeat (6) step(8'hB7, 8'h00, 1'b0);
    chk("hold_code", 8'(code[0]), 8'h03);
    repeat (8) step(8'hB7, 8'h00, 1'b1);
    repeat (4) step(8'hFF, 8'h00, 1'b1);
    repeat (8) step(8'h7D, 8'h80, 1'b1);
    chk("mask_pending", pending[0], 8'h80);
    chk("mask_gs_n", 8'(gs_n[0]), 8'h01);
    repeat (6) step(8'h7D, 8'h00, 1'b1);
    repeat (4) step(8'hFF, 8'h00, 1'b1);
    repeat (6) step(8'hFB, 8'h00, 1'b0);
    repeat (4) step(8'hFF, 8'h00, 1'b0);
    step(8'hFB, 8'h00, 1'b0);
    step(8'hFB, 8'h00, 1'b0);
    step(8'hFB, 8'h00, 1'b1);
    chk("setwins_pending", pending[0], 8'h04);
    repeat (6) step(8'hFB, 8'h00, 1'b1);
    r = 8'hFF;
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
      m = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
      step(r, m, $urandom_range(9) < 7);
    end
    repeat (4) step(8'hFF, 8'h00, 1'b1);
    n = 0;
    while (!m_valid[0] && n < 20) begin
      step(n[0] ? 8'hFF : 8'hEE, 8'h00, 1'b0);
      n++;
    end
    chk("present_reached", 8'(m_valid[0]), 8'h01);
    rst = 1'b1;
    #1;
    chk("async_valid0", 8'(valid[0]), 8'h00);
    chk("async_valid1", 8'(valid[1]), 8'h00);
    chk("async_pending", pending[0], 8'h00);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) step(8'hFF, 8'h00, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
